// File: rtl/coeff_pack_ctrl.sv
// coeff_pack_ctrl: packs the low L bits of every coefficient lane into a continuous W-bit word stream
// Ports: clk/rst (async active-high); encode_lvl latched on the first beat of a polynomial;
// di/in_valid/in_ready/in_last input beats; dout/out_valid/out_ready/out_last output words;
// busy while a polynomial is in flight; err sticky on an illegal level.
module coeff_pack_ctrl #(
  parameter int OUTPUT_W = 4,
  parameter int COEFF_W  = 23,
  parameter int MAX_LVL  = 20,
  parameter int W        = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4:0]                  encode_lvl,
  input  logic [OUTPUT_W*COEFF_W-1:0] di,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  output logic [W-1:0]                dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        err
);
  localparam int BUF_W = 192;
  localparam int PKT_W = OUTPUT_W * MAX_LVL;
  localparam logic [7:0] W8  = 8'(W);
  localparam logic [7:0] LIM = 8'(BUF_W - PKT_W);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [BUF_W-1:0] sbuf, sbuf_n;
  logic [7:0] cnt, cnt_n, base, plen;
  logic [4:0] lvl, lvl_eff;
  logic [PKT_W-1:0] pkt;
  logic [COEFF_W-1:0] lane;
  logic drop, legal, acc, pop, take, fin;
  assign legal   = encode_lvl != 5'd0 && encode_lvl <= 5'(MAX_LVL);
  // the first beat is packed with the level on the wire, later beats with the latched one
  assign lvl_eff = state == IDLE ? encode_lvl : lvl;
  assign acc     = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign fin     = pop && out_last;
  assign take    = acc && (state == RUN || (state == IDLE && !drop && legal));
  assign plen    = 8'(OUTPUT_W) * {3'b000, lvl_eff};
  always_comb begin
    pkt  = '0;
    lane = '0;
    for (int i = 0; i < OUTPUT_W; i++) begin
      lane = di[i*COEFF_W +: COEFF_W] & ~({COEFF_W{1'b1}} << lvl_eff);
      pkt  = pkt | (PKT_W'(lane) << (i * lvl_eff));
    end
  end
  // a pop frees the low word first, so a coincident packet lands at cnt-W
  always_comb begin
    base   = pop ? (cnt > W8 ? cnt - W8 : 8'd0) : cnt;
    sbuf_n = fin ? '0 : ((pop ? sbuf >> W : sbuf) | (take ? BUF_W'(pkt) << base : '0));
    cnt_n  = fin ? 8'd0 : base + (take ? plen : 8'd0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && take) state_n = in_last ? FLUSH : RUN;
    if (state == RUN && take && in_last) state_n = FLUSH;
    if (state == FLUSH && fin) state_n = IDLE;
  end
  always_comb begin
    dout      = sbuf[W-1:0];
    out_valid = state == RUN ? cnt >= W8 : (state == FLUSH && cnt != 8'd0);
    out_last  = state == FLUSH && cnt != 8'd0 && cnt <= W8;
    busy      = state != IDLE;
  end
  // drop swallows the rest of a polynomial whose first beat carried an illegal level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sbuf     <= '0;
      cnt      <= 8'd0;
      lvl      <= 5'd0;
      err      <= 1'b0;
      drop     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      sbuf     <= sbuf_n;
      cnt      <= cnt_n;
      in_ready <= (cnt_n <= LIM) && (state_n != FLUSH);
      if (state == IDLE && acc && !drop && legal) lvl <= encode_lvl;
      if (state == IDLE && acc && !drop && !legal) err <= 1'b1;
      drop <= drop ? !(acc && in_last) : (state == IDLE && acc && !legal && !in_last);
    end
endmodule

// File: tb/tb_coeff_pack_ctrl.sv
// tb_coeff_pack_ctrl: directed checks of coeff_pack_ctrl against a bit-serial reference packing
module tb_coeff_pack_ctrl;
  localparam int NL = 4, CW = 23, W = 64;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] encode_lvl = 5'd0;
  logic [NL*CW-1:0] di = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last, busy, err;
  logic [W-1:0] dout;
  int n_cmp = 0, n_bad = 0, lows = 0;
  logic [NL*CW-1:0] bd [64];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] first_word;

  coeff_pack_ctrl dut (
    .clk(clk), .rst(rst), .encode_lvl(encode_lvl), .di(di), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_last"}, 64'(out_last), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  // mode 0: random lanes, 1: every lane 0xF, 2: lanes {1,2,3,4}; nw is the hand-computed word count
  task automatic run_poly(input int lvl, input int nb, input int mode, input bit rnd, input int nw);
    bit bq [$];
    logic [W-1:0] w, pd;
    bit legal, stalled, pl, acc, pop, fl, started, done;
    int bi, wi, mcnt, cyc, tail;
    legal = lvl >= 1 && lvl <= 20;
    for (int b = 0; b < nb; b++)
      for (int l = 0; l < NL; l++)
        bd[b][l*CW +: CW] = mode == 1 ? 23'hF : mode == 2 ? 23'(l + 1) : 23'($urandom);
    exp_q.delete();
    if (legal)
      for (int b = 0; b < nb; b++)
        for (int l = 0; l < NL; l++)
          for (int k = 0; k < lvl; k++) bq.push_back(bd[b][l*CW + k]);
    while (bq.size() > 0) begin
      w = '0;
      for (int k = 0; k < W && bq.size() > 0; k++) w[k] = bq.pop_front();
      exp_q.push_back(w);
    end
    bi = 0; wi = 0; mcnt = 0; cyc = 0; tail = 0; lows = 0;
    stalled = 0; pl = 0; pd = '0; fl = 0; started = 0; done = 0;
    while (!done && cyc < 3000) begin
      in_valid   = bi < nb;
      di         = bi < nb ? bd[bi] : '0;
      in_last    = bi == nb - 1;
      encode_lvl = bi == 0 ? 5'(lvl) : 5'd7;
      out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (legal) begin
        chk("in_ready", 64'(in_ready), 64'(mcnt <= 112 && !fl));
        chk("out_valid", 64'(out_valid), 64'(fl ? mcnt > 0 : mcnt >= W));
        chk("busy", 64'(busy), 64'(started));
      end else chk("no_out_valid", 64'(out_valid), 0);
      if (stalled) begin
        chk("stall_dout", dout, pd);
        chk("stall_last", 64'(out_last), 64'(pl));
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        chk($sformatf("word%0d", wi), dout, wi < exp_q.size() ? exp_q[wi] : 'x);
        chk($sformatf("last%0d", wi), 64'(out_last), 64'(wi == nw - 1));
        if (wi == 0) first_word = dout;
        wi++;
        mcnt = mcnt > W ? mcnt - W : 0;
        if (out_last) begin
          fl = 0;
          started = 0;
          done = 1;
        end
      end
      if (acc) begin
        if (legal) begin
          mcnt += NL * lvl;
          started = 1;
          if (in_last) fl = 1;
        end
        bi++;
      end
      if (started && !fl && !in_ready) lows++;
      stalled = out_valid && !out_ready;
      pd = dout;
      pl = out_last;
      if (!legal && bi == nb && ++tail > 4) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("timeout", 0, 1);
    chk("word_count", 64'(wi), 64'(nw));
    if (legal) begin
      chk("end_busy", 64'(busy), 0);
      chk("end_in_ready", 64'(in_ready), 1);
      chk("end_out_valid", 64'(out_valid), 0);
    end
    in_valid = 0;
    in_last = 0;
    out_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, cyc;
    #1 rst = 1'b1;
    #1 chk_idle_outs("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("pre_edge_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 1);

    run_poly(10, 1, 2, 0, 1);
    chk("req034_word", first_word, 64'h0000000100300801);
    run_poly(4, 64, 1, 0, 16);
    chk("req035_word", first_word, 64'hFFFF_FFFF_FFFF_FFFF);
    run_poly(20, 64, 0, 0, 80);
    chk("req036_backpressure", 64'(lows > 0), 1);
    run_poly(3, 64, 0, 1, 12);
    run_poly(0, 5, 0, 0, 0);
    chk("req038_err_set", 64'(err), 1);
    run_poly(6, 64, 0, 0, 24);
    chk("req038_err_sticky", 64'(err), 1);

    n = 0; cyc = 0;
    in_valid = 1; out_ready = 1; encode_lvl = 5'd13;
    while (n < 10 && cyc < 100) begin
      di = {4{23'($urandom)}};
      in_last = 0;
      #1;
      if (in_valid && in_ready) n++;
      @(posedge clk); #1;
      encode_lvl = 5'd7;
      cyc++;
    end
    chk("req039_busy_before_rst", 64'(busy), 1);
    rst = 1'b1;
    #1 chk_idle_outs("req039_rst");
    in_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_idle_outs("req039_rst_held");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("req039_in_ready", 64'(in_ready), 1);
    run_poly(13, 8, 0, 0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/coeff_pack_ctrl.md
COEFF_PACK_CTRL -- requirements
Module: coeff_pack_ctrl

Interface
REQ-001 SHALL have parameter OUTPUT_W, default 4, coefficients per input beat.
REQ-002 SHALL have parameter COEFF_W, default 23, width of each coefficient lane in di.
REQ-003 SHALL have parameter MAX_LVL, default 20, largest legal encode level in bits.
REQ-004 SHALL have parameter W, default 64, output word width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port encode_lvl, input, 5, bits kept per coefficient; sampled on first beat of a polynomial.
REQ-008 SHALL have port di, input, OUTPUT_W*COEFF_W, coefficients; lane 0 in di[22:0], lane i in di[23i+22:23i].
REQ-009 SHALL have port in_valid, input, 1, di/in_last valid.
REQ-010 SHALL have port in_ready, output, 1, registered; beat accepted when in_valid and in_ready are both 1.
REQ-011 SHALL have port in_last, input, 1, marks final beat of a polynomial.
REQ-012 SHALL have port dout, output, W, packed word.
REQ-013 SHALL have port out_valid, output, 1, dout valid.
REQ-014 SHALL have port out_ready, input, 1, word consumed when out_valid and out_ready are both 1 (pop).
REQ-015 SHALL have port out_last, output, 1, marks final word of a polynomial.
REQ-016 SHALL have port busy, output, 1, high in RUN and FLUSH.
REQ-017 SHALL have port err, output, 1, sticky illegal-level flag.

Function
REQ-018 SHALL hold a 192-bit bit buffer buf and an 8-bit fill count cnt (0..192).
REQ-019 SHALL form each accepted beat into a packet of 4*L bits, with L the latched level: lane i masked to its low L bits, placed at packet bit offset i*L.
REQ-020 SHALL append the packet at buf bit offset cnt; buf bits at and above the new cnt are zero.
REQ-021 SHALL present dout = buf[W-1:0]; on pop, buf shifts right by W and cnt drops by W, saturating at 0.
REQ-022 SHALL, when accept and pop coincide, compute the new buf as (buf >> W) OR (packet << (cnt-W)), and the new cnt as cnt - W + 4*L.
REQ-023 SHALL register in_ready = 1 iff the next cnt <= 112 and the next state is IDLE or RUN.
REQ-024 SHALL implement states IDLE, RUN and FLUSH.
REQ-025 SHALL, in IDLE on an accepted beat with 1 <= encode_lvl <= MAX_LVL, latch L, absorb the beat, and go to FLUSH if in_last, else RUN.
REQ-026 SHALL, in IDLE on a beat with encode_lvl = 0 or > MAX_LVL, set err, discard beats up to and including in_last, and produce no output.
REQ-027 SHALL, in RUN, absorb beats, ignore encode_lvl, assert out_valid iff cnt >= W, and go to FLUSH when a beat with in_last is accepted.
REQ-028 SHALL, in FLUSH, hold in_ready = 0, assert out_valid iff cnt > 0, and assert out_last iff 0 < cnt <= W; a partial final word is zero-padded.
REQ-029 SHALL return to IDLE on the pop with out_last = 1, leaving cnt = 0 and buf = 0.
REQ-030 SHALL hold dout, out_valid and out_last stable while out_valid = 1 and out_ready = 0.
REQ-031 SHALL have a latency of one cycle from accept to the resulting out_valid.

Reset
REQ-032 SHALL, while rst = 1, asynchronously force state = IDLE, buf = 0, cnt = 0, L = 0, err = 0, in_ready = 0, and out_valid = out_last = busy = 0.
REQ-033 SHALL set in_ready = 1 on the first clk edge after rst falls; reset mid-polynomial drops all buffered bits with no out_last.

Verification
REQ-034 SHALL cover: lvl = 10, one beat di lanes {1,2,3,4} with in_last -> one word dout = 0x0000000100300801, out_last = 1.
REQ-035 SHALL cover: lvl = 4, 64 beats all lanes 0xF, out_ready = 1 -> 16 words of all-ones, out_last only on the 16th.
REQ-036 SHALL cover: lvl = 20, 64 beats -> 80 words; in_ready drops whenever cnt > 112; no bit lost or duplicated against the reference packing.
REQ-037 SHALL cover: lvl = 3, 64 beats with random out_ready -> 12 words, outputs stable while stalled, last word full with no padding.
REQ-038 SHALL cover: lvl = 0 polynomial -> err = 1, no out_valid; a following lvl = 6 polynomial -> 24 correct words with err still 1.
REQ-039 SHALL cover: rst pulsed after 10 beats at lvl = 13 -> all outputs 0 during reset; a fresh polynomial then packs correctly.
